// File: rtl/ber_test_ctrl_pkg.sv
// Shared types and defaults for the BER test sequencer and its tx-bit buffer.
package ber_test_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAIN_RST,
    ST_FLUSH,
    ST_MEASURE,
    ST_DONE
  } state_t;

  // States in which tx bits are buffered and rx bits consumed
  function automatic logic in_window(input state_t s);
    return (s == ST_FLUSH) || (s == ST_MEASURE);
  endfunction

endpackage

// File: rtl/ber_test_ctrl_bit_fifo.sv
// 1-bit first-word-fall-through FIFO holding transmitted bits until their echo returns.
module ber_test_ctrl_bit_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic wr_data,
  output logic rd_data_c,
  output logic ovf_c,
  output logic unf_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             full_c;
  logic             empty_c;
  logic             do_push_c;
  logic             do_pop_c;

  // Extra pointer MSB distinguishes full from empty
  always_comb begin
    empty_c   = (wr_ptr == rd_ptr);
    full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    unf_c     = pop && empty_c;
    ovf_c     = push && full_c && !pop;
    do_pop_c  = pop && !empty_c;
    do_push_c = push && (!full_c || do_pop_c);
    rd_data_c = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are never read while empty
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ber_test_ctrl.sv
// BER run sequencer: resets and enables the datapath chain, compares echoed bits, reports result.
module ber_test_ctrl
  import ber_test_ctrl_pkg::*;
#(
  parameter int unsigned TEST_BITS  = 1000,
  parameter int unsigned FLUSH_BITS = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ERR_LIMIT  = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             chain_rstn,
  output logic             chain_en,
  input  logic             tx_bit,
  input  logic             tx_bit_valid,
  input  logic             rx_bit,
  input  logic             rx_bit_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fifo_err,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned FL_W = (FLUSH_BITS > 1) ? $clog2(FLUSH_BITS) : 1;

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [FL_W-1:0]   flush_cnt;

  logic              start_go_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_head_c;
  logic              fifo_ovf_c;
  logic              fifo_unf_c;
  logic              last_bit_c;
  logic [CNT_W-1:0]  bit_next_c;
  logic [CNT_W-1:0]  err_next_c;

  always_comb begin
    start_go_c = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    push_c     = tx_bit_valid && in_window(state);
    pop_c      = rx_bit_valid && in_window(state);
    bit_next_c = bit_count + CNT_W'(1);
    last_bit_c = (bit_next_c == CNT_W'(TEST_BITS));
    err_next_c = err_count;
    if ((rx_bit != fifo_head_c) && (err_count != '1)) err_next_c = err_count + CNT_W'(1);
  end

  ber_test_ctrl_bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_go_c),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (tx_bit),
    .rd_data_c (fifo_head_c),
    .ovf_c     (fifo_ovf_c),
    .unf_c     (fifo_unf_c)
  );

  // Sequencer with registered outputs; abort outranks start, FIFO faults outrank compares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rst_cnt    <= '0;
      flush_cnt  <= '0;
      chain_rstn <= 1'b0;
      chain_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fifo_err   <= 1'b0;
      bit_count  <= '0;
      err_count  <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      state      <= ST_IDLE;
      chain_rstn <= 1'b0;
      chain_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (start_go_c) begin
      state      <= ST_CHAIN_RST;
      rst_cnt    <= '0;
      flush_cnt  <= '0;
      chain_rstn <= 1'b0;
      chain_en   <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fifo_err   <= 1'b0;
      bit_count  <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        ST_CHAIN_RST: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state      <= (FLUSH_BITS == 0) ? ST_MEASURE : ST_FLUSH;
            chain_rstn <= 1'b1;
            chain_en   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        ST_FLUSH, ST_MEASURE: begin
          if (fifo_ovf_c || fifo_unf_c) begin
            state    <= ST_DONE;
            fifo_err <= 1'b1;
            chain_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
          end else if (pop_c && (state == ST_FLUSH)) begin
            flush_cnt <= flush_cnt + FL_W'(1);
            if (flush_cnt == FL_W'(FLUSH_BITS - 1)) state <= ST_MEASURE;
          end else if (pop_c) begin
            bit_count <= bit_next_c;
            err_count <= err_next_c;
            if (last_bit_c) begin
              state    <= ST_DONE;
              chain_en <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next_c <= CNT_W'(ERR_LIMIT));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Bench for ber_test_ctrl: loopback channel stimulus, queue-based reference model, directed checks.
module tb_ber_test_ctrl;

  localparam int TB_TEST  = 1000;
  localparam int TB_FLUSH = 8;
  localparam int TB_RST   = 4;
  localparam int TB_DEPTH = 16;
  localparam int TB_LIM   = 0;
  localparam int TB_LAT   = 12;

  localparam int P_IDLE = 0, P_RST = 1, P_FLUSH = 2, P_MEAS = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_bit = 1'b0;
  logic        tx_bit_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        rx_bit_valid = 1'b0;
  logic        chain_rstn;
  logic        chain_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fifo_err;
  logic [31:0] bit_count;
  logic [31:0] err_count;

  int checks = 0;
  int failures = 0;

  ber_test_ctrl #(
    .TEST_BITS  (TB_TEST),
    .FLUSH_BITS (TB_FLUSH),
    .RST_CYCLES (TB_RST),
    .FIFO_DEPTH (TB_DEPTH),
    .ERR_LIMIT  (TB_LIM),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .chain_rstn   (chain_rstn),
    .chain_en     (chain_en),
    .tx_bit       (tx_bit),
    .tx_bit_valid (tx_bit_valid),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fifo_err     (fifo_err),
    .bit_count    (bit_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Loopback channel: rx is tx delayed by TB_LAT valid bits, optionally one rx bit inverted
  int flip_idx = -1;
  bit ovf_mode = 1'b0;
  int drv_pushes = 0;
  int rx_idx = 0;
  bit hist[$];

  always begin
    @(posedge clk);
    #1;
    if (!chain_en) begin
      tx_bit_valid = 1'b0;
      rx_bit_valid = 1'b0;
      if (!chain_rstn) begin
        hist.delete();
        rx_idx = 0;
        drv_pushes = 0;
      end
    end else begin
      tx_bit = 1'($urandom);
      tx_bit_valid = 1'b1;
      drv_pushes++;
      if (ovf_mode) begin
        rx_bit_valid = 1'b0;
      end else begin
        hist.push_back(tx_bit);
        if (hist.size() > TB_LAT) begin
          rx_bit = hist.pop_front() ^ (rx_idx == flip_idx);
          rx_bit_valid = 1'b1;
          rx_idx++;
        end else begin
          rx_bit_valid = 1'b0;
        end
      end
    end
  end

  // Reference model: run phase plus a queue standing in for the tx-bit buffer
  int          m_phase = P_IDLE;
  int          m_rstc = 0;
  int          m_flushed = 0;
  int          m_bits = 0;
  logic [31:0] m_errs = '0;
  bit          m_ferr = 1'b0;
  bit          m_pass = 1'b0;
  bit          m_q[$];

  task automatic model_reset();
    m_phase = P_IDLE;
    m_rstc = 0;
    m_flushed = 0;
    m_bits = 0;
    m_errs = '0;
    m_ferr = 1'b0;
    m_pass = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit head;
    bit fault;
    if (abort && m_phase != P_IDLE) begin
      m_phase = P_IDLE;
      m_pass = 1'b0;
    end else if (start && !abort && (m_phase == P_IDLE || m_phase == P_DONE)) begin
      m_phase = P_RST;
      m_rstc = 0;
      m_flushed = 0;
      m_bits = 0;
      m_errs = '0;
      m_ferr = 1'b0;
      m_pass = 1'b0;
      m_q.delete();
    end else if (m_phase == P_RST) begin
      m_rstc++;
      if (m_rstc == TB_RST) m_phase = (TB_FLUSH == 0) ? P_MEAS : P_FLUSH;
    end else if (m_phase == P_FLUSH || m_phase == P_MEAS) begin
      fault = (rx_bit_valid && m_q.size() == 0) ||
              (tx_bit_valid && !rx_bit_valid && m_q.size() == TB_DEPTH);
      if (fault) begin
        m_ferr = 1'b1;
        m_pass = 1'b0;
        m_phase = P_DONE;
      end else begin
        head = 1'b0;
        if (rx_bit_valid) head = m_q.pop_front();
        if (tx_bit_valid) m_q.push_back(tx_bit);
        if (rx_bit_valid && m_phase == P_FLUSH) begin
          m_flushed++;
          if (m_flushed == TB_FLUSH) m_phase = P_MEAS;
        end else if (rx_bit_valid) begin
          m_bits++;
          if (rx_bit != head && m_errs != 32'hFFFF_FFFF) m_errs++;
          if (m_bits == TB_TEST) begin
            m_phase = P_DONE;
            m_pass = !m_ferr && (m_errs <= 32'(TB_LIM));
          end
        end
      end
    end
  endtask

  // Compare every cycle on the falling edge, then advance the model with the inputs about to be sampled
  always @(negedge clk) begin
    if (rst) model_reset();
    check("cyc_chain_rstn", 32'(chain_rstn), 32'(m_phase == P_FLUSH || m_phase == P_MEAS || m_phase == P_DONE));
    check("cyc_chain_en",   32'(chain_en),   32'(m_phase == P_FLUSH || m_phase == P_MEAS));
    check("cyc_busy",       32'(busy),       32'(m_phase == P_RST || m_phase == P_FLUSH || m_phase == P_MEAS));
    check("cyc_done",       32'(done),       32'(m_phase == P_DONE));
    check("cyc_pass",       32'(pass),       32'(m_pass));
    check("cyc_fifo_err",   32'(fifo_err),   32'(m_ferr));
    check("cyc_bit_count",  bit_count,       32'(m_bits));
    check("cyc_err_count",  err_count,       m_errs);
    if (!rst) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000 && !done; i++) tick();
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_bits(input string name, input int n);
    for (int i = 0; i < 4000 && bit_count < 32'(n); i++) tick();
    check({name, "_reached"}, 32'(bit_count >= 32'(n)), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check("rst_chain_rstn", 32'(chain_rstn), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Start latency: chain held in reset for 4 cycles, enabled on the 5th
    pulse_start();
    check("lat_busy_c1", 32'(busy), 32'd1);
    check("lat_rstn_c1", 32'(chain_rstn), 32'd0);
    repeat (3) tick();
    check("lat_rstn_c4", 32'(chain_rstn), 32'd0);
    check("lat_en_c4", 32'(chain_en), 32'd0);
    tick();
    check("lat_rstn_c5", 32'(chain_rstn), 32'd1);
    check("lat_en_c5", 32'(chain_en), 32'd1);
    wait_done("clean");
    check("clean_bits", bit_count, 32'd1000);
    check("clean_errs", err_count, 32'd0);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_fifo_err", 32'(fifo_err), 32'd0);
    repeat (3) tick();
    check("clean_frozen_bits", bit_count, 32'd1000);

    // 20th measured bit inverted
    flip_idx = TB_FLUSH + 19;
    pulse_start();
    wait_done("flip_meas");
    check("flip_meas_errs", err_count, 32'd1);
    check("flip_meas_pass", 32'(pass), 32'd0);
    check("flip_meas_bits", bit_count, 32'd1000);

    // Corruption inside the flush window is discarded
    flip_idx = 3;
    pulse_start();
    wait_done("flip_flush");
    check("flip_flush_errs", err_count, 32'd0);
    check("flip_flush_pass", 32'(pass), 32'd1);
    flip_idx = -1;

    // No rx traffic: the 17th push overflows the 16-deep buffer
    ovf_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && drv_pushes < 17; i++) tick();
    check("ovf_pushes", 32'(drv_pushes), 32'd17);
    tick();
    check("ovf_fifo_err", 32'(fifo_err), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_pass", 32'(pass), 32'd0);
    ovf_mode = 1'b0;
    tick();

    // Abort mid-measure, then a clean rerun
    pulse_start();
    wait_bits("abort", 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_en", 32'(chain_en), 32'd0);
    check("abort_rstn", 32'(chain_rstn), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    pulse_start();
    wait_done("rerun");
    check("rerun_pass", 32'(pass), 32'd1);
    check("rerun_bits", bit_count, 32'd1000);

    // Asynchronous reset mid-measure takes effect without a clock edge
    pulse_start();
    wait_bits("rst_mid", 100);
    rst = 1'b1;
    #1;
    check("rst_mid_rstn", 32'(chain_rstn), 32'd0);
    check("rst_mid_en", 32'(chain_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_bits", bit_count, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_rstn", 32'(chain_rstn), 32'd0);
    tick();
    check("sa_busy_later", 32'(busy), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
